dircc_link_buffer: RTL and testbench

Per-link Avalon-ST packet buffer placed directly upstream of each `dircc_routing` input (`input_north/east/south/west/here`). It absorbs back-pressure from the router so a neighbouring link or the local core can keep streaming. It stores 32-bit words together with their framing (sop, eop, empty) in a show-ahead FIFO. A compile-time option makes it store-and-forward, so the router never sees a partial packet stalled mid-link.

---
 rtl/dircc_link_buffer.sv | 124 ++++++++++++
 tb/tb_dircc_link_buffer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dircc_link_buffer.sv
// Show-ahead Avalon-ST link buffer in front of a dircc_routing input; stores {empty, eop, sop, data}.
// Define DIRCC_LINK_BUFFER_STORE_FORWARD_EN to hold packets until their eop is buffered.
module dircc_link_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [31:0]       sink_data,
    input  logic              sink_valid,
    output logic              sink_ready,
    input  logic              sink_startofpacket,
    input  logic              sink_endofpacket,
    input  logic [1:0]        sink_empty,
    output logic [31:0]       source_data,
    output logic              source_valid,
    input  logic              source_ready,
    output logic              source_startofpacket,
    output logic              source_endofpacket,
    output logic [1:0]        source_empty,
    output logic [ADDR_W:0]   fill_level
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [35:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;
    logic              full;
    logic [35:0]       head;

    assign full       = (count_q == FULL_COUNT);
    assign sink_ready = !full && reset_reset_n;
    assign push       = sink_valid && sink_ready;
    assign pop        = source_valid && source_ready;
    assign fill_level = count_q;

    assign head                 = mem_q[rd_ptr_q];
    assign source_data          = head[31:0];
    assign source_startofpacket = head[32];
    assign source_endofpacket   = head[33];
    assign source_empty         = head[35:34];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; pointers alone define the contents.
    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {sink_empty, sink_endofpacket, sink_startofpacket, sink_data};
        end
    end

`ifdef DIRCC_LINK_BUFFER_STORE_FORWARD_EN
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic             fwd_lock_q, fwd_lock_d;
    logic             push_eop;
    logic             pop_eop;

    assign push_eop = push && sink_endofpacket;
    assign pop_eop  = pop && head[33];

    // A full buffer with no eop inside streams out cut-through; the lock keeps that packet moving.
    assign source_valid = (count_q != '0) && ((pkt_count_q != '0) || full || fwd_lock_q);

    always_comb begin
        pkt_count_d = pkt_count_q;
        fwd_lock_d  = fwd_lock_q;
        if (push_eop && !pop_eop) begin
            pkt_count_d = pkt_count_q + CNT_W'(1);
        end else if (pop_eop && !push_eop) begin
            pkt_count_d = pkt_count_q - CNT_W'(1);
        end
        if (pop_eop) begin
            fwd_lock_d = 1'b0;
        end else if (pop && full) begin
            fwd_lock_d = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pkt_count_q <= '0;
            fwd_lock_q  <= 1'b0;
        end else begin
            pkt_count_q <= pkt_count_d;
            fwd_lock_q  <= fwd_lock_d;
        end
    end
`else
    assign source_valid = (count_q != '0);
`endif

endmodule

// File: tb/tb_dircc_link_buffer.sv
// Randomized and directed bench for dircc_link_buffer against a queue-based packet model.
module tb_dircc_link_buffer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       sink_data = '0;
    logic              sink_valid = 1'b0;
    logic              sink_ready;
    logic              sink_startofpacket = 1'b0;
    logic              sink_endofpacket = 1'b0;
    logic [1:0]        sink_empty = '0;
    logic [31:0]       source_data;
    logic              source_valid;
    logic              source_ready = 1'b0;
    logic              source_startofpacket;
    logic              source_endofpacket;
    logic [1:0]        source_empty;
    logic [ADDR_W:0]   fill_level;

    dircc_link_buffer #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk_clk             (clk),
        .reset_reset_n       (rst_n),
        .sink_data           (sink_data),
        .sink_valid          (sink_valid),
        .sink_ready          (sink_ready),
        .sink_startofpacket  (sink_startofpacket),
        .sink_endofpacket    (sink_endofpacket),
        .sink_empty          (sink_empty),
        .source_data         (source_data),
        .source_valid        (source_valid),
        .source_ready        (source_ready),
        .source_startofpacket(source_startofpacket),
        .source_endofpacket  (source_endofpacket),
        .source_empty        (source_empty),
        .fill_level          (fill_level)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model: queue of {empty, eop, sop, data} words plus the oversize-packet lock.
    logic [35:0] mq[$];
    bit          lock = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic bit m_valid();
        if (mq.size() == 0) return 1'b0;
`ifdef DIRCC_LINK_BUFFER_STORE_FORWARD_EN
        if (mq.size() == DEPTH || lock) return 1'b1;
        foreach (mq[i]) if (mq[i][33]) return 1'b1;
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    // Called at a falling edge: drive, check, advance one clock, update model.
    task automatic step(input bit v, input logic [31:0] d, input bit sop, input bit eop,
                        input logic [1:0] emp, input bit rdy, output bit acc);
        bit          exp_rdy, exp_v, do_pop, was_full;
        logic [35:0] w;
        sink_valid = v; sink_data = d; sink_startofpacket = sop;
        sink_endofpacket = eop; sink_empty = emp; source_ready = rdy;
        #1;
        exp_rdy = (mq.size() != DEPTH);
        exp_v   = m_valid();
        check_eq("sink_ready", 64'(sink_ready), 64'(exp_rdy));
        check_eq("fill_level", 64'(fill_level), 64'(mq.size()));
        check_eq("source_valid", 64'(source_valid), 64'(exp_v));
        if (exp_v)
            check_eq("source_word",
                     64'({source_empty, source_endofpacket, source_startofpacket, source_data}),
                     64'(mq[0]));
        acc      = v && exp_rdy;
        do_pop   = exp_v && rdy;
        was_full = (mq.size() == DEPTH);
        @(posedge clk);
        if (do_pop) begin
            w = mq.pop_front();
            if (w[33]) lock = 1'b0;
            else if (was_full) lock = 1'b1;
        end
        if (acc) mq.push_back({emp, eop, sop, d});
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int unsigned idx;
        int unsigned guard;

        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_source_valid", 64'(source_valid), 64'(0));
        check_eq("rst_sink_ready", 64'(sink_ready), 64'(0));
        check_eq("rst_fill_level", 64'(fill_level), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, one-cycle latency, then pop.
        step(1, 32'hDEADBEEF, 1, 1, 2'd2, 0, acc);
        step(0, 32'h0, 0, 0, 2'd0, 0, acc);
        step(0, 32'h0, 0, 0, 2'd0, 1, acc);
        step(0, 32'h0, 0, 0, 2'd0, 0, acc);

        // Fill to DEPTH with no eop, then pop one and drain in order.
        for (int i = 0; i < DEPTH; i++) step(1, 32'(i), i == 0, 0, 2'd0, 0, acc);
        step(1, 32'h99, 0, 0, 2'd0, 0, acc);
        check_eq("full_rejects_push", 64'(acc), 64'(0));
        step(0, 32'h0, 0, 0, 2'd0, 1, acc);
        for (int i = 1; i < DEPTH + 2; i++) step(0, 32'h0, 0, 0, 2'd0, 1, acc);

        // Continuous single-word packets across pointer wrap.
        for (int i = 0; i < 100; i++) step(1, 32'(1000 + i), 1, 1, 2'(i), 1, acc);
        step(0, 32'h0, 0, 0, 2'd0, 1, acc);

        // Five-word packet at one word every two cycles.
        for (int i = 0; i < 5; i++) begin
            step(1, 32'(500 + i), i == 0, i == 4, 2'd0, 1, acc);
            step(0, 32'h0, 0, 0, 2'd0, 1, acc);
        end
        repeat (6) step(0, 32'h0, 0, 0, 2'd0, 1, acc);

        // Oversize 20-word packet; words retried until accepted.
        idx = 0; guard = 0;
        while (idx < 20 && guard < 200) begin
            step(1, 32'(2000 + idx), idx == 0, idx == 19, 2'd1, 1, acc);
            if (acc) idx++;
            guard++;
        end
        check_eq("pkt20_pushed", 64'(idx), 64'(20));
        repeat (DEPTH + 4) step(0, 32'h0, 0, 0, 2'd0, 1, acc);

        // Random traffic.
        for (int i = 0; i < 1500; i++)
            step(($urandom % 4) != 0, $urandom, ($urandom % 4) == 0, ($urandom % 4) == 0,
                 2'($urandom), ($urandom % 3) != 0, acc);

        // Reset with seven words buffered.
        repeat (DEPTH + 4) step(0, 32'h0, 0, 0, 2'd0, 1, acc);
        for (int i = 0; i < 7; i++) step(1, 32'(3000 + i), 1, 1, 2'd0, 0, acc);
        sink_valid = 1'b0; source_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_source_valid", 64'(source_valid), 64'(0));
        check_eq("midrst_fill_level", 64'(fill_level), 64'(0));
        check_eq("midrst_sink_ready", 64'(sink_ready), 64'(0));
        mq.delete();
        lock = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 7; i < 17; i++) step(1, 32'(3000 + i), 1, 1, 2'd3, ($urandom % 2) == 1, acc);
        repeat (DEPTH + 2) step(0, 32'h0, 0, 0, 2'd0, 1, acc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
